alu_mul_seq: RTL and testbench

- Multi-cycle sequencer that performs a 16x16 unsigned multiply by time-multiplexing the shared 16-bit ALU with the shift-add algorithm.
- Sits between the execute-stage issue logic and the ALU. Drives every ALU control and operand input, and consumes the ALU's Out and Ofl (carry-out).
- Returns a 32-bit product after a fixed 16 iterations, using a start/busy/done handshake.

---
 rtl/alu_mul_seq.sv | 141 ++++++++++++++
 tb/tb_alu_mul_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_mul_seq
// Purpose  : 16x16 unsigned shift-add multiplier. It reuses a shared 16-bit
//            ALU for one add per cycle and produces a 32-bit product after
//            16 iterations. Handshake is start / busy / done.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            start, mcand, mplier - request and operands (captured on accept)
//            busy, done          - RUN indicator, one-cycle completion pulse
//            product[31:0]       - registered result, held until next accept
//            alu_A/B/Cin/Op/invA/invB/sign - ALU control and operand drive
//            alu_Out, alu_Ofl    - ALU sum and carry-out of bit 15
// Revision : 1.0 - initial release
// ============================================================================
module alu_mul_seq #(
    parameter logic [2:0] OP_ADD    = 3'b100,
    parameter bit         ZERO_SKIP = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] mcand,
    input  logic [15:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [31:0] product,
    output logic [15:0] alu_A,
    output logic [15:0] alu_B,
    output logic        alu_Cin,
    output logic [2:0]  alu_Op,
    output logic        alu_invA,
    output logic        alu_invB,
    output logic        alu_sign,
    input  logic [15:0] alu_Out,
    input  logic        alu_Ofl
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_acc;
    logic [15:0] r_q;
    logic [15:0] r_m;
    logic [4:0]  r_cnt;
    logic [31:0] r_product;

    logic        w_accept;
    logic        w_zero;
    logic        w_last;
    logic [31:0] w_shifted;

    // A new request is only taken when no multiply is in flight.
    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_zero    = ZERO_SKIP && ((mcand == 16'h0000) || (mplier == 16'h0000));
    assign w_last    = (r_cnt == 5'd15);
    // The carry-out becomes the new top bit; the bit leaving acc enters q.
    assign w_shifted = {alu_Ofl, alu_Out, r_q[15:1]};

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (w_accept) begin
                    w_next_state = w_zero ? S_DONE : S_RUN;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= 16'h0000;
            r_q       <= 16'h0000;
            r_m       <= 16'h0000;
            r_cnt     <= 5'd0;
            r_product <= 32'h0000_0000;
        end else if (w_accept) begin
            r_m       <= mcand;
            r_q       <= w_zero ? 16'h0000 : mplier;
            r_acc     <= 16'h0000;
            r_cnt     <= 5'd0;
            r_product <= 32'h0000_0000;
        end else if (r_state == S_RUN) begin
            {r_acc, r_q} <= w_shifted;
            r_cnt        <= r_cnt + 5'd1;
            // Load the result on the final iteration so it is valid in DONE.
            if (w_last) begin
                r_product <= w_shifted;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign product  = r_product;

    assign alu_A    = (r_state == S_RUN) ? r_acc : 16'h0000;
    assign alu_B    = ((r_state == S_RUN) && r_q[0]) ? r_m : 16'h0000;
    assign alu_Cin  = 1'b0;
    assign alu_Op   = OP_ADD;
    assign alu_invA = 1'b0;
    assign alu_invB = 1'b0;
    assign alu_sign = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mul_seq
// Purpose  : Directed self-checking bench for alu_mul_seq, with a behavioural
//            16-bit ALU closing the loop. A second instance has ZERO_SKIP=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mul_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT with ZERO_SKIP = 0 ----------------
    logic        start;
    logic [15:0] mcand, mplier;
    logic        busy, done;
    logic [31:0] product;
    logic [15:0] alu_A, alu_B, alu_Out;
    logic        alu_Cin, alu_invA, alu_invB, alu_sign, alu_Ofl;
    logic [2:0]  alu_Op;

    alu_mul_seq #(.OP_ADD(3'b100), .ZERO_SKIP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
        .busy(busy), .done(done), .product(product),
        .alu_A(alu_A), .alu_B(alu_B), .alu_Cin(alu_Cin), .alu_Op(alu_Op),
        .alu_invA(alu_invA), .alu_invB(alu_invB), .alu_sign(alu_sign),
        .alu_Out(alu_Out), .alu_Ofl(alu_Ofl)
    );

    // Behavioural ALU: add with optional operand inversion and carry-in.
    logic [15:0] a_eff, b_eff;
    assign a_eff = alu_invA ? ~alu_A : alu_A;
    assign b_eff = alu_invB ? ~alu_B : alu_B;
    assign {alu_Ofl, alu_Out} = {1'b0, a_eff} + {1'b0, b_eff} + {16'h0000, alu_Cin};

    // ---------------- DUT with ZERO_SKIP = 1 ----------------
    logic        zs_start;
    logic [15:0] zs_mcand, zs_mplier;
    logic        zs_busy, zs_done;
    logic [31:0] zs_product;
    logic [15:0] zs_A, zs_B, zs_Out;
    logic        zs_Cin, zs_invA, zs_invB, zs_sign, zs_Ofl;
    logic [2:0]  zs_Op;

    alu_mul_seq #(.OP_ADD(3'b100), .ZERO_SKIP(1'b1)) dut_zs (
        .clk(clk), .rst_n(rst_n), .start(zs_start), .mcand(zs_mcand), .mplier(zs_mplier),
        .busy(zs_busy), .done(zs_done), .product(zs_product),
        .alu_A(zs_A), .alu_B(zs_B), .alu_Cin(zs_Cin), .alu_Op(zs_Op),
        .alu_invA(zs_invA), .alu_invB(zs_invB), .alu_sign(zs_sign),
        .alu_Out(zs_Out), .alu_Ofl(zs_Ofl)
    );

    assign {zs_Ofl, zs_Out} = {1'b0, (zs_invA ? ~zs_A : zs_A)} +
                              {1'b0, (zs_invB ? ~zs_B : zs_B)} + {16'h0000, zs_Cin};

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one multiply on the ZERO_SKIP=0 instance and check the whole
    // transaction: busy length, done latency, product, ALU constants, hold.
    task automatic run_mul(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp);
        int n;
        int busy_cycles;
        int const_bad;
        @(negedge clk);
        start = 1'b1; mcand = a; mplier = b;
        @(posedge clk); #1;                 // edge 0: accepted
        busy_cycles = busy ? 1 : 0;
        const_bad = 0;
        @(negedge clk);
        start = 1'b0; mcand = 16'h5A5A; mplier = 16'hA5A5;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (busy) busy_cycles++;
            if (alu_Op !== 3'b100 || alu_sign !== 1'b0 || alu_Cin !== 1'b0 ||
                alu_invA !== 1'b0 || alu_invB !== 1'b0) const_bad++;
        end
        chk({tag, "_latency"}, n, 16);
        chk({tag, "_busy_cycles"}, busy_cycles, 16);
        chk({tag, "_product"}, product, exp);
        chk({tag, "_alu_ctrl"}, const_bad, 0);
        @(posedge clk); #1;
        chk({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
        chk({tag, "_hold"}, product, exp);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        int busy_seen;
        start = 1'b0; mcand = 16'h0; mplier = 16'h0;
        zs_start = 1'b0; zs_mcand = 16'h0; zs_mplier = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_product", product, 32'd0);
        chk("reset_aluA", {16'd0, alu_A}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic multiplies and alignment corners.
        run_mul("m3x5",      16'h0003, 16'h0005, 32'h0000_000F);
        run_mul("mFFFFxFFFF", 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
        run_mul("m8000x2",   16'h8000, 16'h0002, 32'h0001_0000);
        run_mul("m1x8000",   16'h0001, 16'h8000, 32'h0000_8000);
        run_mul("m0xABCD_noskip", 16'h0000, 16'hABCD, 32'h0000_0000);

        // start held high during RUN is ignored; re-sampled in DONE.
        @(negedge clk);
        start = 1'b1; mcand = 16'h0003; mplier = 16'h0005;
        @(posedge clk); #1;                 // accepted 3x5
        @(negedge clk);
        mcand = 16'h0007; mplier = 16'h0009; // start stays high
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_first_latency", n, 16);
        chk("hold_first_product", product, 32'h0000_000F);
        @(negedge clk);
        @(posedge clk); #1;                 // DONE edge accepted 7x9
        chk("hold_reaccept_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_second_latency", n, 16);
        chk("hold_second_product", product, 32'h0000_003F);
        @(posedge clk); #1;

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1; mcand = 16'h1234; mplier = 16'h0010;
        @(posedge clk); #1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_busy", {31'd0, busy}, 32'd0);
        chk("areset_done", {31'd0, done}, 32'd0);
        chk("areset_product", product, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) n++;
        end
        chk("areset_no_done", n, 0);
        run_mul("m1234x10", 16'h1234, 16'h0010, 32'h0001_2340);

        // ZERO_SKIP instance: zero operand completes in one cycle.
        @(negedge clk);
        zs_start = 1'b1; zs_mcand = 16'h0000; zs_mplier = 16'hABCD;
        @(posedge clk); #1;
        chk("zs_done_next", {31'd0, zs_done}, 32'd1);
        chk("zs_busy", {31'd0, zs_busy}, 32'd0);
        chk("zs_product", zs_product, 32'd0);
        @(negedge clk);
        zs_start = 1'b0;
        @(posedge clk); #1;
        chk("zs_idle", {30'd0, zs_busy, zs_done}, 32'd0);
        // Non-zero operands on the ZERO_SKIP instance still take the full path.
        @(negedge clk);
        zs_start = 1'b1; zs_mcand = 16'h0007; zs_mplier = 16'h0009;
        @(posedge clk); #1;
        @(negedge clk);
        zs_start = 1'b0;
        n = 0; busy_seen = 0;
        while (!zs_done && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (zs_busy) busy_seen++;
        end
        chk("zs_full_latency", n, 16);
        chk("zs_full_product", zs_product, 32'h0000_003F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
